// File: rtl/spi_flash_reader_if.sv
// Request, received-byte stream and SPI pin bundle of the flash reader.
// The slave view belongs to the reader; the master view belongs to its client and the flash.
interface spi_flash_reader_if;
    logic        start;
    logic [23:0] addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        spi_cs;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_miso;

    modport slave (
        input  start, addr, len, out_ready, spi_miso,
        output busy, done, out_data, out_valid, spi_cs, spi_clk, spi_mosi
    );

    modport master (
        output start, addr, len, out_ready, spi_miso,
        input  busy, done, out_data, out_valid, spi_cs, spi_clk, spi_mosi
    );
endinterface

// File: rtl/spi_flash_reader.sv
// SPI mode-0 flash READ (0x03) initiator: sends opcode and 24-bit address, then
// streams len bytes into a one-byte valid/ready buffer, pausing SCK while it is full.
module spi_flash_reader #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_HIGH = 4
) (
    input  logic                clk,
    input  logic                reset,
    spi_flash_reader_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, SETUP, HDR, RD, STALL, HOLD, GAP} state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(CS_HIGH - 1);

    state_t      state;
    logic [15:0] tick;
    logic [15:0] remain;
    logic [4:0]  bit_cnt;
    logic [31:0] shreg;
    logic [7:0]  rx;
    logic        cs, sck, mosi, busy, done, out_valid;
    logic [7:0]  out_data;

    logic        phase_end;
    logic        buf_free;
    logic [31:0] hdr_word;

    assign phase_end = (tick == DIV_LAST);
    assign buf_free  = !out_valid || bus.out_ready;
    assign hdr_word  = {8'h03, bus.addr};

    assign bus.spi_cs    = cs;
    assign bus.spi_clk   = sck;
    assign bus.spi_mosi  = mosi;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.out_data  = out_data;
    assign bus.out_valid = out_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tick      <= '0;
            remain    <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx        <= '0;
            cs        <= 1'b1;
            sck       <= 1'b0;
            mosi      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            // Consumer handshake; a byte load later in this block overrides the clear.
            if (out_valid && bus.out_ready)
                out_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shreg  <= hdr_word;
                        remain <= bus.len;
                        if (bus.len == 16'd0) begin
                            done <= 1'b1;
                        end else begin
                            busy  <= 1'b1;
                            cs    <= 1'b0;
                            mosi  <= hdr_word[31];
                            tick  <= '0;
                            state <= SETUP;
                        end
                    end
                end

                SETUP: begin
                    if (phase_end) begin
                        tick    <= '0;
                        bit_cnt <= '0;
                        state   <= HDR;
                    end else begin
                        tick <= tick + 16'd1;
                    end
                end

                HDR: begin
                    if (!phase_end) begin
                        tick <= tick + 16'd1;
                    end else begin
                        tick <= '0;
                        if (!sck) begin
                            sck <= 1'b1;
                        end else begin
                            sck     <= 1'b0;
                            shreg   <= {shreg[30:0], 1'b0};
                            mosi    <= shreg[30];
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd31) begin
                                mosi  <= 1'b0;
                                state <= RD;
                            end
                        end
                    end
                end

                RD: begin
                    if (!phase_end) begin
                        tick <= tick + 16'd1;
                    end else begin
                        tick <= '0;
                        if (!sck) begin
                            sck <= 1'b1;
                        end else begin
                            // Sample on the last high clk, together with the falling edge.
                            sck     <= 1'b0;
                            rx      <= {rx[6:0], bus.spi_miso};
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt[2:0] == 3'd7) begin
                                bit_cnt <= '0;
                                if (buf_free) begin
                                    out_data  <= {rx[6:0], bus.spi_miso};
                                    out_valid <= 1'b1;
                                    remain    <= remain - 16'd1;
                                    if (remain == 16'd1)
                                        state <= HOLD;
                                end else begin
                                    state <= STALL;
                                end
                            end
                        end
                    end
                end

                STALL: begin
                    if (buf_free) begin
                        out_data  <= rx;
                        out_valid <= 1'b1;
                        remain    <= remain - 16'd1;
                        tick      <= '0;
                        state     <= (remain == 16'd1) ? HOLD : RD;
                    end
                end

                HOLD: begin
                    if (phase_end) begin
                        cs    <= 1'b1;
                        tick  <= '0;
                        state <= GAP;
                    end else begin
                        tick <= tick + 16'd1;
                    end
                end

                GAP: begin
                    if (tick == GAP_LAST) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        tick  <= '0;
                        state <= IDLE;
                    end else begin
                        tick <= tick + 16'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader with a behavioural SPI flash responder.
module tb_spi_flash_reader;
    logic clk = 1'b0;
    logic reset = 1'b1;

    spi_flash_reader_if bus ();

    spi_flash_reader #(.CLK_DIV(2), .CS_HIGH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Flash responder and pin monitor, sampled just after each rising clk edge.
    logic [7:0]  resp [16];
    logic [31:0] hdr_cap = '0;
    logic        miso_q = 1'b0;
    logic        sck_prev = 1'b0;
    logic        cs_prev = 1'b1;
    logic [7:0]  cur;
    int unsigned rise_cnt = 0, k = 0, cyc = 0;
    int unsigned sck_rises = 0, cs_low_cyc = 0, busy_cyc = 0, valid_cyc = 0, done_cnt = 0;
    int unsigned cs_fall_cyc = 0, cs_rise_cyc = 0, first_rise_cyc = 0, done_cyc = 0;

    assign bus.spi_miso = miso_q;

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (bus.spi_cs) begin
            rise_cnt = 0;
        end else begin
            if (bus.spi_clk && !sck_prev) begin
                if (rise_cnt == 0) first_rise_cyc = cyc;
                if (rise_cnt < 32) hdr_cap = {hdr_cap[30:0], bus.spi_mosi};
                rise_cnt++;
                sck_rises++;
            end
            if (!bus.spi_clk && sck_prev && rise_cnt >= 32) begin
                k = rise_cnt - 32;
                cur = resp[(k / 8) % 16];
                miso_q = cur[7 - (k % 8)];
            end
        end
        if (!bus.spi_cs && cs_prev) cs_fall_cyc = cyc;
        if (bus.spi_cs && !cs_prev) cs_rise_cyc = cyc;
        if (!bus.spi_cs) cs_low_cyc++;
        if (bus.busy) busy_cyc++;
        if (bus.out_valid) valid_cyc++;
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        sck_prev = bus.spi_clk;
        cs_prev  = bus.spi_cs;
    end

    // Handshakes are logged on the inputs the next rising edge will see.
    logic [7:0]  rx_log [64];
    int unsigned rx_cnt = 0;

    always begin
        @(negedge clk);
        #1;
        if (bus.out_valid && bus.out_ready) begin
            rx_log[rx_cnt % 64] = bus.out_data;
            rx_cnt++;
        end
    end

    int unsigned snap_rises, snap_cs, snap_busy, snap_valid, snap_done, snap_rx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic take_snap();
        snap_rises = sck_rises;
        snap_cs    = cs_low_cyc;
        snap_busy  = busy_cyc;
        snap_valid = valid_cyc;
        snap_done  = done_cnt;
        snap_rx    = rx_cnt;
    endtask

    task automatic do_start(input logic [23:0] a, input logic [15:0] l);
        @(negedge clk);
        take_snap();
        bus.start = 1'b1;
        bus.addr  = a;
        bus.len   = l;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int unsigned n = 0;
        while (bus.done !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(bus.done), 32'd1);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.addr      = '0;
        bus.len       = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) resp[i] = 8'h00;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_cs",    32'(bus.spi_cs),    32'd1);
        check("rst_sck",   32'(bus.spi_clk),   32'd0);
        check("rst_mosi",  32'(bus.spi_mosi),  32'd0);
        check("rst_busy",  32'(bus.busy),      32'd0);
        check("rst_done",  32'(bus.done),      32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data",  32'(bus.out_data),  32'd0);
        reset = 1'b0;
        take_snap();
        repeat (20) @(negedge clk);
        check("idle_cs_low", cs_low_cyc - snap_cs,    32'd0);
        check("idle_sck",    sck_rises - snap_rises,  32'd0);
        check("idle_busy",   busy_cyc - snap_busy,    32'd0);
        check("idle_valid",  valid_cyc - snap_valid,  32'd0);

        // Single byte read
        resp[0] = 8'hA5;
        do_start(24'h123456, 16'd1);
        wait_done("t1_done_seen");
        check("t1_header",     hdr_cap,                        32'h03123456);
        check("t1_rx_count",   rx_cnt - snap_rx,               32'd1);
        check("t1_rx_byte",    32'(rx_log[snap_rx % 64]),      32'h000000A5);
        check("t1_valid_cyc",  valid_cyc - snap_valid,         32'd1);
        check("t1_cs_low",     cs_low_cyc - snap_cs,           32'd164);
        check("t1_busy_cyc",   busy_cyc - snap_busy,           32'd168);
        check("t1_sck_rises",  sck_rises - snap_rises,         32'd40);
        check("t1_first_sck",  first_rise_cyc - cs_fall_cyc,   32'd4);
        check("t1_done_gap",   done_cyc - cs_rise_cyc,         32'd4);
        check("t1_busy_at_done", 32'(bus.busy),                32'd0);
        @(negedge clk);
        check("t1_done_pulse", done_cnt - snap_done,           32'd1);

        // Four bytes with a stalled consumer
        resp[0] = 8'h00; resp[1] = 8'hFF; resp[2] = 8'h5A; resp[3] = 8'hC3;
        bus.out_ready = 1'b0;
        do_start(24'h00ABCD, 16'd4);
        repeat (249) @(negedge clk);
        check("t2_stall_rises", sck_rises - snap_rises, 32'd48);
        check("t2_stall_sck",   32'(bus.spi_clk),       32'd0);
        check("t2_stall_valid", 32'(bus.out_valid),     32'd1);
        check("t2_stall_data",  32'(bus.out_data),      32'd0);
        repeat (20) @(negedge clk);
        check("t2_still_stall", sck_rises - snap_rises, 32'd48);
        repeat (30) @(negedge clk);
        bus.out_ready = 1'b1;
        wait_done("t2_done_seen");
        check("t2_header",   hdr_cap,                   32'h0300ABCD);
        check("t2_rx_count", rx_cnt - snap_rx,          32'd4);
        check("t2_byte0",    32'(rx_log[(snap_rx + 0) % 64]), 32'h00);
        check("t2_byte1",    32'(rx_log[(snap_rx + 1) % 64]), 32'hFF);
        check("t2_byte2",    32'(rx_log[(snap_rx + 2) % 64]), 32'h5A);
        check("t2_byte3",    32'(rx_log[(snap_rx + 3) % 64]), 32'hC3);
        check("t2_rises",    sck_rises - snap_rises,    32'd64);
        check("t2_valid_end", 32'(bus.out_valid),       32'd0);

        // Zero length
        do_start(24'h000010, 16'd0);
        check("t3_done_next", 32'(bus.done), 32'd1);
        check("t3_busy",      32'(bus.busy), 32'd0);
        @(negedge clk);
        check("t3_done_clear", 32'(bus.done), 32'd0);
        repeat (10) @(negedge clk);
        check("t3_cs_low",  cs_low_cyc - snap_cs,   32'd0);
        check("t3_busy_cyc", busy_cyc - snap_busy,  32'd0);
        check("t3_one_done", done_cnt - snap_done,  32'd1);

        // Reset during byte 2 of an eight-byte read
        for (int i = 0; i < 8; i++) resp[i] = 8'(8'h40 + i);
        do_start(24'h000100, 16'd8);
        begin
            int unsigned n = 0;
            while ((sck_rises - snap_rises) < 44 && n < 2000) begin
                @(negedge clk);
                n++;
            end
        end
        check("t4_reached_byte2", 32'((sck_rises - snap_rises) >= 44), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("t4_rst_cs",    32'(bus.spi_cs),    32'd1);
        check("t4_rst_sck",   32'(bus.spi_clk),   32'd0);
        check("t4_rst_valid", 32'(bus.out_valid), 32'd0);
        check("t4_rst_busy",  32'(bus.busy),      32'd0);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("t4_no_done", done_cnt - snap_done, 32'd0);
        resp[0] = 8'h11; resp[1] = 8'h22;
        do_start(24'h0A0B0C, 16'd2);
        wait_done("t4_restart_done");
        check("t4_header",   hdr_cap,                         32'h030A0B0C);
        check("t4_rx_count", rx_cnt - snap_rx,                32'd2);
        check("t4_byte0",    32'(rx_log[(snap_rx + 0) % 64]), 32'h11);
        check("t4_byte1",    32'(rx_log[(snap_rx + 1) % 64]), 32'h22);

        // Start while busy is ignored
        resp[0] = 8'h3C;
        do_start(24'h654321, 16'd1);
        repeat (10) @(negedge clk);
        bus.start = 1'b1;
        bus.addr  = 24'hFFFFFF;
        bus.len   = 16'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("t5_done_seen");
        check("t5_header",   hdr_cap,                    32'h03654321);
        check("t5_rx_count", rx_cnt - snap_rx,           32'd1);
        check("t5_byte0",    32'(rx_log[snap_rx % 64]),  32'h3C);
        check("t5_rises",    sck_rises - snap_rises,     32'd40);
        repeat (60) @(negedge clk);
        check("t5_one_done", done_cnt - snap_done,       32'd1);
        check("t5_cs_idle",  32'(bus.spi_cs),            32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_flash_reader.md
Name: spi_flash_reader

Overview:
- SPI mode-0 bus initiator that drives a real flash part. It issues READ (0x03) plus a 24-bit address, then clocks in a requested number of data bytes.
- Received bytes leave through a one-byte valid/ready buffer. SCK pauses between bytes when the consumer stalls.
- Used to image or verify the external flash into SDRAM, opposite the emulated flash responder on the same bus protocol.

Parameters:
- CLK_DIV, 2: clk cycles per SCK half-period. Legal range 1..255.
- CS_HIGH, 4: minimum clk cycles spi_cs stays high after a transaction before the next one may begin.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high
- start  input  1  one-cycle request; ignored while busy=1
- addr  input  24  flash byte address, latched on accepted start
- len  input  16  byte count, latched on accepted start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse at transaction end
- out_data  output  8  received byte
- out_valid  output  1  out_data holds an unconsumed byte
- out_ready  input  1  consumer accepts when out_valid and out_ready are both high
- spi_cs  output  1  chip select, active low; high when idle
- spi_clk  output  1  SCK; low when idle
- spi_mosi  output  1  serial out, MSB first
- spi_miso  input  1  serial in, MSB first

Behaviour:
- Reset values: spi_cs=1, spi_clk=0, spi_mosi=0, busy=0, done=0, out_valid=0, out_data=0. Reset mid-transaction aborts on the next clk edge; no done pulse is issued.
- Accepted start means start=1 in IDLE. It latches {8'h03, addr} into a 32-bit shift register and latches len into the remaining-byte counter.
- len=0: no bus activity, spi_cs stays 1, done pulses the cycle after start, busy never rises.
- States:
  - IDLE: waits for an accepted start with len!=0, then enters SETUP.
  - SETUP: spi_cs=0 and spi_mosi=bit31. Holds CLK_DIV cycles, then enters HDR.
  - HDR: 32 bits. Each bit is CLK_DIV cycles low then CLK_DIV cycles high. spi_mosi updates on the falling edge (after the high phase). After the 32nd high phase, SCK returns low and the state goes to RD.
  - RD: same bit timing with spi_mosi=0. spi_miso is sampled into the rx shift register on the last clk of each high phase, which is just before the falling edge.
  - After the 8th sample: if out_valid=0, or out_valid=1 with out_ready=1 in that cycle, load out_data and set out_valid=1 on the next edge. Otherwise go to STALL, holding the byte with SCK low.
  - STALL: leaves on the first cycle the output buffer frees, loads the byte, and continues.
  - After each loaded byte, the counter decrements. At 0 the state goes to HOLD; otherwise the next RD byte starts with no SCK gap.
  - HHOLD: SCK low for CLK_DIV cycles, then spi_cs=1 and the state goes to GAP.
  - GAP: spi_cs=1 for CS_HIGH cycles, then done=1 for one cycle, busy=0, and the state returns to IDLE.
- out_valid clears when out_valid and out_ready are both high, unless a new byte loads in the same cycle; the load wins.
- out_valid may stay set after done; the last byte remains until consumed.
- The remaining-byte counter is 16-bit with no wrap, so len=65535 reads exactly 65535 bytes.
- The flash address is not incremented in RTL; the flash auto-increments. An address crossing 0xFFFFFF wraps inside the flash and is not checked here.
- Latency:
  - First SCK rising edge occurs 2*CLK_DIV cycles after spi_cs falls.
  - Header lasts 64*CLK_DIV cycles.
  - Each data byte with no stall lasts 16*CLK_DIV cycles.
  - out_valid rises 1 cycle after the 8th sample.
- start while busy: ignored, with no effect on the latched addr or len.

Test Plan:
- Reset, then idle 20 cycles -> spi_cs=1, spi_clk=0, busy=0, out_valid=0 throughout.
- CLK_DIV=2, start with addr=0x123456, len=1, flash model returns 0xA5, out_ready=1:
  - MOSI bits across 32 rising edges equal 0x03123456.
  - out_data=0xA5 with out_valid high for exactly 1 cycle.
  - done arrives CS_HIGH cycles after spi_cs rises.
  - spi_cs is low for 2+64*2+16*2+2=164 cycles... more precisely, 4 setup+hold cycles plus 160 cycles of SCK activity.
- len=4, model returns 0x00,0xFF,0x5A,0xC3, out_ready=0 until cycle 300 -> SCK stops low after byte 1 is buffered and byte 2 is received, resumes after the handshake, and all 4 bytes arrive in order.
- len=0 start -> done the next cycle, spi_cs never falls, busy stays 0.
- reset asserted during byte 2 of a len=8 read -> next cycle spi_cs=1, spi_clk=0, out_valid=0, and no done. A new start afterwards completes normally.
- start pulsed while busy with a different addr -> header still carries the original addr, and only one done is issued.
